signed_divider: RTL and testbench

- Sequential signed integer divider; the inverse of the 16x16 combinational signed multiplier.
- Accepts a 32-bit signed dividend (typically a product P) and a 16-bit signed divisor.
- Returns quotient and remainder after an iterative restoring division, one quotient bit per cycle.
- Sits beside the multiplier as its arithmetic counterpart, with valid/ready handshakes on both sides.

---
 rtl/signed_divider.sv | 209 ++++++++++++++++++++
 tb/tb_signed_divider.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
// -----------------------------------------------------------------------------
// SignedDivider (module signed_divider)
//
// Sequential signed integer divider. It is the arithmetic counterpart of the
// 16x16 combinational signed multiplier: it takes a 32-bit signed dividend and
// a 16-bit signed divisor and produces a quotient and remainder by restoring
// division on the operand magnitudes, one quotient bit per clock. Signs are
// applied in a final fix-up cycle. The results follow SystemVerilog signed
// division: the quotient truncates toward zero, and the remainder takes the
// sign of the dividend.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (aborts any operation in flight)
//   in_valid   operands N/D are presented
//   in_ready   divider is idle and can accept an operation
//   N          signed dividend (WIDTH_N bits)
//   D          signed divisor  (WIDTH_D bits)
//   out_valid  Q/R and the flags hold a result
//   out_ready  consumer takes the result
//   Q          signed quotient (WIDTH_N bits)
//   R          signed remainder (WIDTH_D bits)
//   dbz        divide by zero: Q = -1, R = low bits of N
//   ovf        most negative N divided by -1: Q = N (wraps), R = 0
//   fits16     Q is representable as a WIDTH_D-bit signed value
// -----------------------------------------------------------------------------
module signed_divider #(
    parameter int WIDTH_N = 32,
    parameter int WIDTH_D = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_N-1:0] N,
    input  logic [WIDTH_D-1:0] D,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_N-1:0] Q,
    output logic [WIDTH_D-1:0] R,
    output logic               dbz,
    output logic               ovf,
    output logic               fits16
);

    localparam int CW = $clog2(WIDTH_N + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]      r_count;
    logic [WIDTH_N-1:0] r_nq;
    logic [WIDTH_D-1:0] r_rem;
    logic [WIDTH_D-1:0] r_dmag;
    logic               r_sign_q;
    logic               r_sign_r;

    logic               w_dzero;
    logic               w_ovf_case;
    logic [WIDTH_N-1:0] w_nmag;
    logic [WIDTH_D-1:0] w_dmag;
    logic [WIDTH_D:0]   w_shift;
    logic [WIDTH_D:0]   w_diff;
    logic [WIDTH_N-1:0] w_q_signed;
    logic [WIDTH_D-1:0] w_r_signed;
    logic [WIDTH_N-WIDTH_D:0] w_q_top;
    logic               w_fits;

    assign w_dzero    = (D == '0);
    assign w_ovf_case = (N == {1'b1, {(WIDTH_N-1){1'b0}}}) && (D == '1);

    // The most negative dividend negates to itself, which is exactly its
    // magnitude when the bits are read as unsigned, so no extra bit is needed.
    assign w_nmag = N[WIDTH_N-1] ? -N : N;
    assign w_dmag = D[WIDTH_D-1] ? -D : D;

    // The partial remainder is always below |D|, so one extra bit holds the
    // shifted value. The trial difference then lies in [-|D|, |D|-1], so its
    // top bit serves as the sign of the comparison.
    assign w_shift = {r_rem, r_nq[WIDTH_N-1]};
    assign w_diff  = w_shift - {1'b0, r_dmag};

    assign w_q_signed = r_sign_q ? -r_nq  : r_nq;
    assign w_r_signed = r_sign_r ? -r_rem : r_rem;

    // The quotient fits the narrow width when every bit above the narrow sign
    // bit repeats that sign bit.
    assign w_q_top = w_q_signed[WIDTH_N-1:WIDTH_D-1];
    assign w_fits  = (w_q_top == '0) || (w_q_top == '1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake logic. Divide by zero and the single overflow
    // case are resolved at accept time and skip the iteration entirely.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_dzero || w_ovf_case) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (r_count == CW'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath. r_nq starts as |N| and shifts left each iteration. Dividend
    // bits leave at the top into the remainder, and quotient bits enter at the
    // bottom, so after WIDTH_N steps it holds the quotient magnitude. Results
    // change only at accept (special cases) or in FIX, so they stay frozen
    // while a result waits for out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count  <= '0;
            r_nq     <= '0;
            r_rem    <= '0;
            r_dmag   <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            Q        <= '0;
            R        <= '0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
            fits16   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign_q <= N[WIDTH_N-1] ^ D[WIDTH_D-1];
                        r_sign_r <= N[WIDTH_N-1];
                        r_nq     <= w_nmag;
                        r_dmag   <= w_dmag;
                        r_rem    <= '0;
                        dbz      <= 1'b0;
                        ovf      <= 1'b0;
                        fits16   <= 1'b0;
                        if (w_dzero) begin
                            dbz <= 1'b1;
                            Q   <= '1;
                            R   <= N[WIDTH_D-1:0];
                        end else if (w_ovf_case) begin
                            ovf <= 1'b1;
                            Q   <= N;
                            R   <= '0;
                        end else begin
                            r_count <= CNT_INIT;
                        end
                    end
                end
                S_CALC: begin
                    if (w_diff[WIDTH_D]) begin
                        r_rem <= w_shift[WIDTH_D-1:0];
                        r_nq  <= {r_nq[WIDTH_N-2:0], 1'b0};
                    end else begin
                        r_rem <= w_diff[WIDTH_D-1:0];
                        r_nq  <= {r_nq[WIDTH_N-2:0], 1'b1};
                    end
                    r_count <= r_count - 1'b1;
                end
                S_FIX: begin
                    Q      <= w_q_signed;
                    R      <= w_r_signed;
                    fits16 <= w_fits;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_signed_divider
//
// Directed and random testbench for signed_divider. Each scenario task drives
// its own operations and compares the results against values worked out by
// hand. In the random scenario, the expected values come from the simulator's
// own signed / and %. The latency counts start at 1 for the sample taken just
// after the accepting clock edge.
// -----------------------------------------------------------------------------
module tb_signed_divider;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] N;
    logic [15:0] D;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Q;
    logic [15:0] R;
    logic        dbz;
    logic        ovf;
    logic        fits16;

    int checks;
    int errors;

    signed_divider #(.WIDTH_N(32), .WIDTH_D(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .N         (N),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .R         (R),
        .dbz       (dbz),
        .ovf       (ovf),
        .fits16    (fits16)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one operation, waits a bounded time for the result, captures it
    // and acknowledges it. Operands are scrambled right after the accept edge.
    // A lat value of -1 means that no result arrived.
    task automatic applyStimulus(input logic [31:0] n, input logic [15:0] d,
                                 output logic [31:0] q, output logic [15:0] r,
                                 output logic dz, output logic ov,
                                 output logic ft, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        in_valid = 1'b1;
        N        = n;
        D        = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        N        = $urandom;
        D        = 16'($urandom);
        lat      = -1;
        for (int c = 1; c <= 100; c++) begin
            if (out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        q  = Q;
        r  = R;
        dz = dbz;
        ov = ovf;
        ft = fits16;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        N         = '0;
        D         = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        checks++;
        if (Q !== 32'd0 || R !== 16'd0 || dbz !== 1'b0 || ovf !== 1'b0 || fits16 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: Q=%0h R=%0h dbz=%b ovf=%b fits16=%b, required all zero",
                     Q, R, dbz, ovf, fits16);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [31:0] q;
        logic [15:0] r;
        logic dz, ov, ft;
        int lat;
        applyStimulus(32'd100, 16'd7, q, r, dz, ov, ft, lat);
        checks++;
        if (q !== 32'd14 || r !== 16'd2) begin
            errors++;
            $display("[TB] FAIL basic_qr: Q=%0d R=%0d, required 14/2", $signed(q), $signed(r));
        end
        checks++;
        if (dz !== 1'b0 || ov !== 1'b0 || ft !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_flags: dbz=%b ovf=%b fits16=%b, required 0/0/1", dz, ov, ft);
        end
        checks++;
        if (lat != 34) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d, required 34", lat);
        end
    endtask

    task automatic test_sign_matrix();
        logic [31:0] q;
        logic [15:0] r;
        logic dz, ov, ft;
        int lat;
        logic [31:0] vn [3];
        logic [15:0] vd [3];
        logic [31:0] eq [3];
        logic [15:0] er [3];
        vn[0] = -32'sd100; vd[0] =  16'sd7; eq[0] = -32'sd14; er[0] = -16'sd2;
        vn[1] =  32'sd100; vd[1] = -16'sd7; eq[1] = -32'sd14; er[1] =  16'sd2;
        vn[2] = -32'sd100; vd[2] = -16'sd7; eq[2] =  32'sd14; er[2] = -16'sd2;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vn[i], vd[i], q, r, dz, ov, ft, lat);
            checks++;
            if (q !== eq[i] || r !== er[i] || ft !== 1'b1 || lat != 34) begin
                errors++;
                $display("[TB] FAIL sign_%0d: Q=%0d R=%0d fits16=%b lat=%0d, required Q=%0d R=%0d fits16=1 lat=34",
                         i, $signed(q), $signed(r), ft, lat, $signed(eq[i]), $signed(er[i]));
            end
        end
    endtask

    task automatic test_inverse_and_fits();
        logic [31:0] q;
        logic [15:0] r;
        logic dz, ov, ft;
        int lat;
        logic [31:0] vn [6];
        logic [15:0] vd [6];
        logic [31:0] eq [6];
        logic [15:0] er [6];
        logic        ef [6];
        vn[0] = -32'sd3962745;   vd[0] = 16'sd321;    eq[0] = -32'sd12345;   er[0] = 16'd0; ef[0] = 1'b1;
        vn[1] = 32'sd2147483647; vd[1] = 16'sd1;      eq[1] = 32'sd2147483647; er[1] = 16'd0; ef[1] = 1'b0;
        vn[2] = -32'sd32768;     vd[2] = 16'sd1;      eq[2] = -32'sd32768;   er[2] = 16'd0; ef[2] = 1'b1;
        vn[3] = 32'sd32768;      vd[3] = 16'sd1;      eq[3] = 32'sd32768;    er[3] = 16'd0; ef[3] = 1'b0;
        vn[4] = 32'h8000_0000;   vd[4] = 16'sd1;      eq[4] = 32'h8000_0000; er[4] = 16'd0; ef[4] = 1'b0;
        vn[5] = 32'h8000_0000;   vd[5] = 16'h8000;    eq[5] = 32'sd65536;    er[5] = 16'd0; ef[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vn[i], vd[i], q, r, dz, ov, ft, lat);
            checks++;
            if (q !== eq[i] || r !== er[i] || ft !== ef[i] || dz !== 1'b0 || ov !== 1'b0) begin
                errors++;
                $display("[TB] FAIL inverse_%0d: Q=%0d R=%0d fits16=%b dbz=%b ovf=%b, required Q=%0d R=%0d fits16=%b dbz=0 ovf=0",
                         i, $signed(q), $signed(r), ft, dz, ov, $signed(eq[i]), $signed(er[i]), ef[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] q;
        logic [15:0] r;
        logic dz, ov, ft;
        int lat;
        applyStimulus(32'd5, 16'd0, q, r, dz, ov, ft, lat);
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 16'd5 || dz !== 1'b1 || ov !== 1'b0 || ft !== 1'b0 || lat != 1) begin
            errors++;
            $display("[TB] FAIL dbz: Q=%0h R=%0h dbz=%b ovf=%b fits16=%b lat=%0d, required ffffffff/5/1/0/0/1",
                     q, r, dz, ov, ft, lat);
        end
        applyStimulus(32'h8000_0000, 16'hFFFF, q, r, dz, ov, ft, lat);
        checks++;
        if (q !== 32'h8000_0000 || r !== 16'd0 || dz !== 1'b0 || ov !== 1'b1 || ft !== 1'b0 || lat != 1) begin
            errors++;
            $display("[TB] FAIL ovf: Q=%0h R=%0h dbz=%b ovf=%b fits16=%b lat=%0d, required 80000000/0/0/1/0/1",
                     q, r, dz, ov, ft, lat);
        end
        // The flags from a special case clear when the next ordinary operation is accepted.
        applyStimulus(32'd9, 16'd3, q, r, dz, ov, ft, lat);
        checks++;
        if (q !== 32'd3 || r !== 16'd0 || dz !== 1'b0 || ov !== 1'b0 || ft !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flags_clear: Q=%0d R=%0d dbz=%b ovf=%b fits16=%b, required 3/0/0/0/1",
                     $signed(q), $signed(r), dz, ov, ft);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        in_valid = 1'b1;
        N        = 32'd1000;
        D        = -16'sd3;
        @(posedge clk);
        #1;
        // Keep offering a different operation while the divider is busy; it must be ignored.
        N   = 32'd77;
        D   = 16'd5;
        bad = 0;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            if (out_valid) begin
                lat = c;
                break;
            end
            if (in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0 || lat != 34) begin
            errors++;
            $display("[TB] FAIL busy_ready: in_ready high %0d times, lat=%0d, required 0 and 34", bad, lat);
        end
        in_valid = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || Q !== -32'sd333 || R !== 16'd1) bad++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL hold_stable: %0d unstable cycles, last Q=%0d R=%0d, required 0 with Q=-333 R=1",
                     bad, $signed(Q), $signed(R));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] q;
        logic [15:0] r;
        logic dz, ov, ft;
        int lat;
        int bad;
        in_valid = 1'b1;
        N        = 32'd123456;
        D        = 16'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || Q !== 32'd0 || R !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_abort: out_valid=%b in_ready=%b Q=%0h R=%0h, required 0/1/0/0",
                     out_valid, in_ready, Q, R);
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        out_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL reset_no_result: out_valid seen %0d times, required 0", bad);
        end
        applyStimulus(32'd123456, 16'd10, q, r, dz, ov, ft, lat);
        checks++;
        if (q !== 32'd12345 || r !== 16'd6 || lat != 34) begin
            errors++;
            $display("[TB] FAIL after_reset: Q=%0d R=%0d lat=%0d, required 12345/6/34", $signed(q), $signed(r), lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] q;
        logic [15:0] r;
        logic dz, ov, ft;
        int lat;
        logic [31:0] n;
        logic [15:0] d;
        int ni, di, eqi, eri;
        shortint ds;
        logic [31:0] eq;
        logic [15:0] er;
        logic edz, eov, eft;
        int elat;
        for (int i = 0; i < 200; i++) begin
            n = $random;
            d = 16'($random);
            if (i % 25 == 7) d = 16'd0;
            if (i == 100) begin
                n = 32'h8000_0000;
                d = 16'hFFFF;
            end
            ni = int'(n);
            ds = shortint'(d);
            di = int'(ds);
            if (di == 0) begin
                eq = 32'hFFFF_FFFF; er = n[15:0]; edz = 1'b1; eov = 1'b0; eft = 1'b0; elat = 1;
            end else if (n == 32'h8000_0000 && di == -1) begin
                eq = n; er = 16'd0; edz = 1'b0; eov = 1'b1; eft = 1'b0; elat = 1;
            end else begin
                eqi  = ni / di;
                eri  = ni % di;
                eq   = 32'(eqi);
                er   = 16'(eri);
                edz  = 1'b0;
                eov  = 1'b0;
                eft  = (eqi >= -32768) && (eqi <= 32767);
                elat = 34;
            end
            applyStimulus(n, d, q, r, dz, ov, ft, lat);
            checks++;
            if (q !== eq || r !== er) begin
                errors++;
                $display("[TB] FAIL random_%0d_qr: N=%0d D=%0d Q=%0d R=%0d, required Q=%0d R=%0d",
                         i, $signed(n), $signed(d), $signed(q), $signed(r), $signed(eq), $signed(er));
            end
            checks++;
            if (dz !== edz || ov !== eov || ft !== eft || lat != elat) begin
                errors++;
                $display("[TB] FAIL random_%0d_flags: dbz=%b ovf=%b fits16=%b lat=%0d, required %b/%b/%b/%0d",
                         i, dz, ov, ft, lat, edz, eov, eft, elat);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_sign_matrix();
        test_inverse_and_fits();
        test_special();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
